// File: rtl/mem_access_pkg.sv
// Shared types for the memory-stage data-bus master: access size, strobe_type
// encodings and FSM state encoding.
package mem_access_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2
  } msize_t;

  localparam logic [1:0] STROBE_WORD = 2'b00;
  localparam logic [1:0] STROBE_HALF = 2'b01;
  localparam logic [1:0] STROBE_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  // The unused 11 encoding falls through to a byte access.
  function automatic msize_t decode_size(input logic [1:0] strobe_type);
    case (strobe_type)
      STROBE_WORD: decode_size = MSIZE4;
      STROBE_HALF: decode_size = MSIZE2;
      default:     decode_size = MSIZE1;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: request size/strobe/replicated write data from the
// live instruction, and load extraction/extension from the latched request.
module mem_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  strobe_type,
  input  logic [1:0]  st_addr_lo,
  input  logic        is_load,
  input  logic [31:0] wdata,
  output msize_t      size,
  output logic [3:0]  strobe,
  output logic [31:0] wdata_rep,
  input  msize_t      ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_sign_ext,
  input  logic [31:0] dresp_data,
  output logic [31:0] load_data
);

  logic [3:0]  lane_mask_s;
  logic [31:0] shifted_s;

  // Store-side size, byte enables and lane replication.
  always_comb begin
    size        = decode_size(strobe_type);
    lane_mask_s = 4'b0000;
    wdata_rep   = wdata;
    case (size)
      MSIZE4: begin
        lane_mask_s = 4'b1111;
        wdata_rep   = wdata;
      end
      MSIZE2: begin
        lane_mask_s = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep   = {2{wdata[15:0]}};
      end
      MSIZE1: begin
        lane_mask_s = 4'b0001 << st_addr_lo;
        wdata_rep   = {4{wdata[7:0]}};
      end
      default: begin
        lane_mask_s = 4'b0000;
        wdata_rep   = wdata;
      end
    endcase
    if (is_load) begin
      strobe = 4'b0000;
    end else begin
      strobe = lane_mask_s;
    end
  end

  // Load-side: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted_s = dresp_data >> {ld_addr_lo, 3'b000};
    case (ld_size)
      MSIZE1:  load_data = {{24{ld_sign_ext & shifted_s[7]}}, shifted_s[7:0]};
      MSIZE2:  load_data = {{16{ld_sign_ext & shifted_s[15]}}, shifted_s[15:0]};
      default: load_data = shifted_s;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-stage data-bus master: issues one dreq per checked load/store, waits
// for the dresp handshake, and stalls the pipeline until the access completes.
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        memtoreg,
  input  logic        mem_write,
  input  logic [1:0]  strobe_type,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        adel,
  input  logic        ades,
  input  logic        flush,
  input  logic        advance,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic [31:0] rdata,
  output logic        stall
);

  mem_state_t  state_r;
  logic        kill_r;
  logic        valid_r;
  logic        is_load_r;
  logic        sign_ext_r;
  logic [31:0] addr_r;
  logic [31:0] data_r;
  logic [31:0] rdata_r;
  msize_t      size_r;
  logic [3:0]  strobe_r;

  logic        start_s;
  logic        killed_s;
  msize_t      size_s;
  logic [3:0]  strobe_s;
  logic [31:0] wdata_rep_s;
  logic [31:0] load_data_s;

  assign start_s  = (memtoreg | mem_write) & ~adel & ~ades & ~flush;
  // A flush arriving together with data_ok still kills the access.
  assign killed_s = kill_r | flush;

  mem_align u_align (
    .strobe_type (strobe_type),
    .st_addr_lo  (addr[1:0]),
    .is_load     (memtoreg),
    .wdata       (wdata),
    .size        (size_s),
    .strobe      (strobe_s),
    .wdata_rep   (wdata_rep_s),
    .ld_size     (size_r),
    .ld_addr_lo  (addr_r[1:0]),
    .ld_sign_ext (sign_ext_r),
    .dresp_data  (dresp_data),
    .load_data   (load_data_s)
  );

  // Access FSM with latched request fields, kill flag and load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      kill_r     <= 1'b0;
      valid_r    <= 1'b0;
      is_load_r  <= 1'b0;
      sign_ext_r <= 1'b0;
      addr_r     <= 32'h0000_0000;
      data_r     <= 32'h0000_0000;
      rdata_r    <= 32'h0000_0000;
      size_r     <= MSIZE1;
      strobe_r   <= 4'b0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            addr_r     <= addr;
            size_r     <= size_s;
            strobe_r   <= strobe_s;
            data_r     <= wdata_rep_s;
            sign_ext_r <= sign_ext;
            is_load_r  <= memtoreg;
            kill_r     <= 1'b0;
            valid_r    <= 1'b1;
            state_r    <= REQ;
          end
        end
        REQ: begin
          if (dresp_addr_ok & dresp_data_ok) begin
            valid_r <= 1'b0;
            kill_r  <= 1'b0;
            if (killed_s) begin
              state_r <= IDLE;
            end else begin
              state_r <= DONE;
              rdata_r <= is_load_r ? load_data_s : 32'h0000_0000;
            end
          end else if (dresp_addr_ok) begin
            valid_r <= 1'b0;
            kill_r  <= killed_s;
            state_r <= WAIT;
          end else begin
            kill_r  <= killed_s;
          end
        end
        WAIT: begin
          if (dresp_data_ok) begin
            kill_r <= 1'b0;
            if (killed_s) begin
              state_r <= IDLE;
            end else begin
              state_r <= DONE;
              rdata_r <= is_load_r ? load_data_s : 32'h0000_0000;
            end
          end else begin
            kill_r <= killed_s;
          end
        end
        DONE: begin
          if (advance) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          kill_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign dreq_valid  = valid_r;
  assign dreq_addr   = addr_r;
  assign dreq_size   = size_r;
  assign dreq_strobe = strobe_r;
  assign dreq_data   = data_r;
  assign rdata       = rdata_r;
  assign stall       = ((state_r == IDLE) & start_s) | (state_r == REQ) | (state_r == WAIT);

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, exception/reset
// sequences and randomized accesses against a lane-arithmetic reference model.
`timescale 1ns/1ps
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset, memtoreg, mem_write, sign_ext, adel, ades, flush, advance;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [1:0]  strobe_type;
  logic [31:0] addr, wdata, dresp_data;
  logic        dreq_valid, stall;
  logic [31:0] dreq_addr, dreq_data, rdata;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .reset(reset), .memtoreg(memtoreg), .mem_write(mem_write),
    .strobe_type(strobe_type), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .adel(adel), .ades(ades), .flush(flush), .advance(advance),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data), .rdata(rdata), .stall(stall)
  );

  typedef struct {
    logic        ld;
    logic [1:0]  st;
    logic        sx;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          ad;      // REQ cycles before addr_ok
    int          dd;      // WAIT cycles before data_ok
    int          kc;      // first cycle of flush (-1: none)
    int          hold;    // extra DONE cycles before advance
    logic [3:0]  e_strobe;
    logic [31:0] e_data;
    logic [2:0]  e_size;
    logic [31:0] e_rdata;
    int          e_stall;
  } txn_t;

  txn_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    memtoreg = 1'b0; mem_write = 1'b0; strobe_type = 2'd0; sign_ext = 1'b0;
    addr = 32'h0; wdata = 32'h0; adel = 1'b0; ades = 1'b0; flush = 1'b0;
    advance = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'h0;
  endtask

  // Reference model from the access rules: byte count, lane arithmetic, extension.
  function automatic txn_t model(input txn_t t, input logic [31:0] prev_rdata);
    int nb;
    int off;
    logic [31:0] v;
    logic [31:0] mask;
    txn_t r;
    r = t;
    nb = (t.st == 2'd0) ? 4 : ((t.st == 2'd1) ? 2 : 1);
    off = int'(t.a[1:0]) & ~(nb - 1);
    r.e_size = (nb == 4) ? 3'd2 : ((nb == 2) ? 3'd1 : 3'd0);
    r.e_strobe = t.ld ? 4'b0000 : 4'(((1 << nb) - 1) << off);
    for (int i = 0; i < 4; i++) begin
      r.e_data[8*i +: 8] = 8'(t.wd >> (8 * (i % nb)));
    end
    mask = (nb == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * nb)) - 64'd1);
    v = (t.rd >> (8 * int'(t.a[1:0]))) & mask;
    if (t.sx && v[8*nb-1]) v = v | ~mask;
    if (t.kc >= 0)      r.e_rdata = prev_rdata;
    else if (t.ld)      r.e_rdata = v;
    else                r.e_rdata = 32'h0;
    r.e_stall = 2 + t.ad + t.dd;
    return r;
  endfunction

  task automatic run_txn(input txn_t t);
    int stalls;
    bit killed;
    killed = (t.kc >= 0);
    @(negedge clk);
    memtoreg = t.ld; mem_write = ~t.ld; strobe_type = t.st; sign_ext = t.sx;
    addr = t.a; wdata = t.wd; flush = 1'b0; advance = 1'b0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'($urandom);
    #1;
    stalls = int'(stall);
    chk("start_stall", 32'(stall), 32'd1);
    chk("start_valid", 32'(dreq_valid), 32'd0);
    for (int c = 0; c <= t.ad + t.dd; c++) begin
      @(negedge clk);
      // Live inputs change after the start cycle; the request must not follow them.
      addr = 32'($urandom); wdata = 32'($urandom);
      strobe_type = 2'($urandom); sign_ext = 1'($urandom);
      if (killed && c >= t.kc) flush = 1'b1;
      #1;
      stalls += int'(stall);
      if (c <= t.ad) begin
        chk("req_valid", 32'(dreq_valid), 32'd1);
        chk("req_addr", dreq_addr, t.a);
        chk("req_size", 32'(dreq_size), 32'(t.e_size));
        chk("req_strobe", 32'(dreq_strobe), 32'(t.e_strobe));
        if (!t.ld) chk("req_data", dreq_data, t.e_data);
      end else begin
        chk("wait_valid", 32'(dreq_valid), 32'd0);
      end
      dresp_addr_ok = (c == t.ad);
      dresp_data_ok = (c == t.ad + t.dd);
      dresp_data = (c == t.ad + t.dd) ? t.rd : 32'($urandom);
    end
    @(negedge clk);
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'($urandom);
    #1;
    chk("end_stall", 32'(stall), 32'd0);
    chk("end_valid", 32'(dreq_valid), 32'd0);
    chk("rdata", rdata, t.e_rdata);
    chk("stall_cycles", 32'(stalls), 32'(t.e_stall));
    if (!killed) begin
      advance = (t.hold == 0);
      for (int h = 1; h <= t.hold; h++) begin
        @(negedge clk);
        #1;
        chk("done_valid", 32'(dreq_valid), 32'd0);
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_rdata", rdata, t.e_rdata);
        advance = (h == t.hold);
      end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    chk("idle_valid", 32'(dreq_valid), 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_rdata", rdata, t.e_rdata);
  endtask

  txn_t rt;
  logic [31:0] exp_r;
  int nb;

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 1'b0, 32'h1000, 32'h0,       32'hDEADBEEF, 0, 0, -1, 1, 4'b0000, 32'h0,       3'd2, 32'hDEADBEEF, 2};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h1003, 32'h000000AB, 32'h0,       3, 0, -1, 0, 4'b1000, 32'hABABABAB, 3'd0, 32'h0,        5};
    tbl[2]  = '{1'b1, 2'd1, 1'b1, 32'h1002, 32'h0,       32'h80FF1234, 0, 1, -1, 0, 4'b0000, 32'h0,       3'd1, 32'hFFFF80FF, 3};
    tbl[3]  = '{1'b1, 2'd1, 1'b0, 32'h1002, 32'h0,       32'h80FF1234, 1, 0, -1, 0, 4'b0000, 32'h0,       3'd1, 32'h000080FF, 3};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h2000, 32'h12345678, 32'h0,       0, 2, -1, 0, 4'b1111, 32'h12345678, 3'd2, 32'h0,        4};
    tbl[5]  = '{1'b0, 2'd1, 1'b0, 32'h2002, 32'h0000CAFE, 32'h0,       0, 0, -1, 0, 4'b1100, 32'hCAFECAFE, 3'd1, 32'h0,        2};
    tbl[6]  = '{1'b1, 2'd2, 1'b1, 32'h3001, 32'h0,       32'h00008000, 0, 0, -1, 0, 4'b0000, 32'h0,       3'd0, 32'hFFFFFF80, 2};
    tbl[7]  = '{1'b1, 2'd0, 1'b0, 32'h4000, 32'h0,       32'h11111111, 0, 3,  1, 0, 4'b0000, 32'h0,       3'd2, 32'hFFFFFF80, 5};
    tbl[8]  = '{1'b1, 2'd2, 1'b0, 32'h3002, 32'h0,       32'h00AB0000, 0, 0, -1, 5, 4'b0000, 32'h0,       3'd0, 32'h000000AB, 2};
    tbl[9]  = '{1'b1, 2'd0, 1'b0, 32'h5000, 32'h0,       32'h22222222, 1, 1,  2, 0, 4'b0000, 32'h0,       3'd2, 32'h000000AB, 4};
    tbl[10] = '{1'b0, 2'd3, 1'b0, 32'h1002, 32'h0000005A, 32'h0,       0, 0, -1, 0, 4'b0100, 32'h5A5A5A5A, 3'd0, 32'h0,        2};

    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(dreq_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_size", 32'(dreq_size), 32'd0);
    chk("rst_strobe", 32'(dreq_strobe), 32'd0);
    chk("rst_addr", dreq_addr, 32'h0);
    chk("rst_data", dreq_data, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_txn(tbl[i]);

    // Exceptions and flush in IDLE suppress the access entirely.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      clear_inputs();
      addr = 32'h6000;
      if (k == 0) begin memtoreg = 1'b1; adel = 1'b1; end
      else if (k == 1) begin mem_write = 1'b1; ades = 1'b1; end
      else begin memtoreg = 1'b1; flush = 1'b1; end
      for (int j = 0; j < 3; j++) begin
        #1;
        chk("blocked_stall", 32'(stall), 32'd0);
        chk("blocked_valid", 32'(dreq_valid), 32'd0);
        @(negedge clk);
      end
      chk("blocked_rdata", rdata, 32'h0);
    end
    clear_inputs();

    // Reset while a request is outstanding abandons it.
    @(negedge clk);
    memtoreg = 1'b1; addr = 32'h7004;
    @(negedge clk);
    #1;
    chk("pre_reset_valid", 32'(dreq_valid), 32'd1);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    #1;
    chk("mid_reset_valid", 32'(dreq_valid), 32'd0);
    chk("mid_reset_stall", 32'(stall), 32'd0);
    reset = 1'b0;

    exp_r = 32'h0;
    for (int n = 0; n < 40; n++) begin
      rt.ld = 1'($urandom);
      rt.st = 2'($urandom);
      rt.sx = 1'($urandom);
      nb = (rt.st == 2'd0) ? 4 : ((rt.st == 2'd1) ? 2 : 1);
      rt.a = 32'($urandom) & ~32'(nb - 1);
      rt.wd = 32'($urandom);
      rt.rd = 32'($urandom);
      rt.ad = int'($urandom_range(3, 0));
      rt.dd = int'($urandom_range(3, 0));
      rt.kc = ($urandom_range(4, 0) == 0) ? int'($urandom_range(rt.ad + rt.dd, 0)) : -1;
      rt.hold = int'($urandom_range(2, 0));
      rt = model(rt, exp_r);
      run_txn(rt);
      exp_r = rt.e_rdata;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
